// File: rtl/gcn_mem_server_if.sv
// rtl/gcn_mem_server_if.sv - load, read and control bundle between gcn loader/core and gcn_mem_server
interface gcn_mem_server_if #(
    parameter int BW          = 5,
    parameter int NUM_ELEM    = 96,
    parameter int NUM_ROWS_FM = 6,
    parameter int NUM_ROWS_WM = 3,
    parameter int BEAT_ELEMS  = 8,
    parameter int COO_W       = 18
) ();
    logic                                       ld_valid;
    logic                                       ld_ready;
    logic [BEAT_ELEMS*BW-1:0]                   ld_data;
    logic                                       clear;
    logic                                       input_re;
    logic [NUM_ROWS_FM-1:0][2:0]                input_addr_fm_row;
    logic [NUM_ROWS_WM-1:0][1:0]                input_addr_wm;
    logic [NUM_ROWS_FM-1:0][NUM_ELEM*BW-1:0]    row_features;
    logic [NUM_ROWS_WM-1:0][NUM_ELEM*BW-1:0]    row_weights;
    logic [1:0][COO_W-1:0]                      COO_mat;
    logic                                       rd_valid;
    logic                                       start;
    logic                                       done;
    logic                                       oor_err;
    logic                                       coo_err;

    modport master (
        output ld_valid, ld_data, clear, input_re, input_addr_fm_row, input_addr_wm, done,
        input  ld_ready, row_features, row_weights, COO_mat, rd_valid, start, oor_err, coo_err
    );

    modport slave (
        input  ld_valid, ld_data, clear, input_re, input_addr_fm_row, input_addr_wm, done,
        output ld_ready, row_features, row_weights, COO_mat, rd_valid, start, oor_err, coo_err
    );
endinterface

// File: rtl/gcn_mem_server.sv
// rtl/gcn_mem_server.sv - streamed-load input memory serving parallel row reads to the gcn core
// Optional COO entry validation on the final load beat is enabled by defining GCN_COO_CHECK_EN.
module gcn_mem_server #(
    parameter int BW          = 5,
    parameter int NUM_ELEM    = 96,
    parameter int NUM_ROWS_FM = 6,
    parameter int NUM_ROWS_WM = 3,
    parameter int BEAT_ELEMS  = 8,
    parameter int COO_W       = 18
) (
    input logic              clk,
    input logic              rst,
    gcn_mem_server_if.slave  bus
);
    localparam int ROW_W   = NUM_ELEM * BW;
    localparam int BEAT_W  = BEAT_ELEMS * BW;
    localparam int BPR     = NUM_ELEM / BEAT_ELEMS;
    localparam int NROWS   = NUM_ROWS_FM + NUM_ROWS_WM;
    localparam int BEAT_IW = $clog2(BPR);
    localparam int ROW_IW  = $clog2(NROWS + 1);
    localparam int FM_AW   = 3;
    localparam int WM_AW   = 2;
    localparam int COO_N   = COO_W / 3;
    localparam logic [6:0] LAST_BEAT = 7'(NROWS * BPR);

    typedef enum logic [2:0] {S_LOAD, S_READY, S_SERVE, S_DONE, S_ERROR} state_t;

    state_t                                 state_q, state_d;
    logic [6:0]                             bc_q, bc_d;
    logic [BEAT_IW-1:0]                     beat_q, beat_d;
    logic [ROW_IW-1:0]                      row_q, row_d;
    logic [NUM_ROWS_FM-1:0][ROW_W-1:0]      rf_q, rf_d;
    logic [NUM_ROWS_WM-1:0][ROW_W-1:0]      rw_q, rw_d;
    logic [1:0][COO_W-1:0]                  coo_q, coo_d;
    logic                                   rd_valid_q, rd_valid_d;
    logic                                   oor_q, oor_d;

    logic [ROW_W-1:0]                       fm_mem [NUM_ROWS_FM];
    logic [ROW_W-1:0]                       wm_mem [NUM_ROWS_WM];

    logic                                   fm_we, wm_we, coo_bad;
    logic [FM_AW-1:0]                       fm_widx;
    logic [WM_AW-1:0]                       wm_widx;

    // Row counter walks feature rows first, then weight rows, then the single COO beat.
    assign fm_widx = row_q[FM_AW-1:0];
    assign wm_widx = WM_AW'(row_q - ROW_IW'(NUM_ROWS_FM));

`ifdef GCN_COO_CHECK_EN
    always_comb begin
        coo_bad = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < COO_N; i++) begin
                if (bus.ld_data[r*COO_W + i*3 +: 3] == 3'd0 ||
                    bus.ld_data[r*COO_W + i*3 +: 3] > 3'(NUM_ROWS_FM))
                    coo_bad = 1'b1;
            end
        end
    end
    assign bus.coo_err = (state_q == S_ERROR);
`else
    assign coo_bad     = 1'b0;
    assign bus.coo_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bc_d       = bc_q;
        beat_d     = beat_q;
        row_d      = row_q;
        rf_d       = rf_q;
        rw_d       = rw_q;
        coo_d      = coo_q;
        rd_valid_d = 1'b0;
        oor_d      = oor_q;
        fm_we      = 1'b0;
        wm_we      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (bus.ld_valid) begin
                    if (bc_q == LAST_BEAT) begin
                        coo_d[0] = bus.ld_data[COO_W-1:0];
                        coo_d[1] = bus.ld_data[2*COO_W-1:COO_W];
                        bc_d     = '0;
                        beat_d   = '0;
                        row_d    = '0;
                        state_d  = coo_bad ? S_ERROR : S_READY;
                    end else begin
                        bc_d  = bc_q + 7'd1;
                        fm_we = (row_q < ROW_IW'(NUM_ROWS_FM));
                        wm_we = !fm_we;
                        if (beat_q == BEAT_IW'(BPR - 1)) begin
                            beat_d = '0;
                            row_d  = row_q + ROW_IW'(1);
                        end else begin
                            beat_d = beat_q + BEAT_IW'(1);
                        end
                    end
                end
            end
            S_READY: state_d = S_SERVE;
            S_SERVE: begin
                if (bus.input_re) begin
                    rd_valid_d = 1'b1;
                    for (int p = 0; p < NUM_ROWS_FM; p++) begin
                        if (bus.input_addr_fm_row[p] < 3'(NUM_ROWS_FM)) begin
                            rf_d[p] = fm_mem[bus.input_addr_fm_row[p]];
                        end else begin
                            rf_d[p] = '0;
                            oor_d   = 1'b1;
                        end
                    end
                    for (int p = 0; p < NUM_ROWS_WM; p++) begin
                        if (bus.input_addr_wm[p] < 2'(NUM_ROWS_WM)) begin
                            rw_d[p] = wm_mem[bus.input_addr_wm[p]];
                        end else begin
                            rw_d[p] = '0;
                            oor_d   = 1'b1;
                        end
                    end
                end
                if (bus.done) state_d = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (bus.clear) begin
                    state_d = S_LOAD;
                    bc_d    = '0;
                    beat_d  = '0;
                    row_d   = '0;
                    oor_d   = 1'b0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            bc_q       <= '0;
            beat_q     <= '0;
            row_q      <= '0;
            rf_q       <= '0;
            rw_q       <= '0;
            coo_q      <= '0;
            rd_valid_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            beat_q     <= beat_d;
            row_q      <= row_d;
            rf_q       <= rf_d;
            rw_q       <= rw_d;
            coo_q      <= coo_d;
            rd_valid_q <= rd_valid_d;
            oor_q      <= oor_d;
        end
    end

    // Storage is never reset; a fresh load overwrites every row.
    always_ff @(posedge clk) begin
        if (fm_we && !rst) fm_mem[fm_widx][int'(beat_q)*BEAT_W +: BEAT_W] <= bus.ld_data;
        if (wm_we && !rst) wm_mem[wm_widx][int'(beat_q)*BEAT_W +: BEAT_W] <= bus.ld_data;
    end

    assign bus.ld_ready     = (state_q == S_LOAD);
    assign bus.start        = (state_q == S_READY);
    assign bus.rd_valid     = rd_valid_q;
    assign bus.oor_err      = oor_q;
    assign bus.row_features = rf_q;
    assign bus.row_weights  = rw_q;
    assign bus.COO_mat      = coo_q;
endmodule
